// File: rtl/cc_apb_master.sv
// rtl/cc_apb_master.sv - single-outstanding APB3 requester with bounded-wait timeout
module cc_apb_master #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_slverr_o,
    output logic              rsp_timeout_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    input  logic              pready_i,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pslverr_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Counter value seen in the final permitted ACCESS cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t     state;
    logic [7:0] to_cnt;

    assign req_ready_o = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            to_cnt        <= '0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            paddr_o       <= '0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_slverr_o  <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        paddr_o  <= req_addr_i;
                        pwrite_o <= req_write_i;
                        pwdata_o <= req_wdata_i;
                        psel_o   <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    penable_o <= 1'b1;
                    to_cnt    <= '0;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    // pready wins over a timeout landing in the same cycle.
                    if (pready_i) begin
                        psel_o        <= 1'b0;
                        penable_o     <= 1'b0;
                        rsp_valid_o   <= 1'b1;
                        rsp_slverr_o  <= pslverr_i;
                        rsp_timeout_o <= 1'b0;
                        rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                        state         <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 8'd1;
                        if (to_cnt == TO_LAST) begin
                            psel_o        <= 1'b0;
                            penable_o     <= 1'b0;
                            rsp_valid_o   <= 1'b1;
                            rsp_slverr_o  <= 1'b1;
                            rsp_timeout_o <= 1'b1;
                            rsp_rdata_o   <= '0;
                            state         <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_apb_master.sv
// tb/tb_cc_apb_master.sv - directed self-checking bench for cc_apb_master
module tb_cc_apb_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_slverr;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic [11:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;

    int total = 0;
    int bad   = 0;
    int n_acc;

    always #5 clk = ~clk;

    cc_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_slverr_o(rsp_slverr), .rsp_timeout_o(rsp_timeout),
        .psel_o(psel), .penable_o(penable), .paddr_o(paddr), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [11:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_cleared", 32'(rsp_valid), 32'd0);
        chk("req_ready_back", 32'(req_ready), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // read with immediate pready
        pready = 1'b1;
        prdata = 32'h0002_2025;
        issue(1'b0, 12'h000, 32'h0);
        chk("rd_setup_psel", 32'(psel), 32'd1);
        chk("rd_setup_penable", 32'(penable), 32'd0);
        chk("rd_setup_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rd_access_psel", 32'(psel), 32'd1);
        chk("rd_access_penable", 32'(penable), 32'd1);
        chk("rd_access_pwrite", 32'(pwrite), 32'd0);
        @(negedge clk);
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h0002_2025);
        chk("rd_rsp_slverr", 32'(rsp_slverr), 32'd0);
        chk("rd_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("rd_resp_psel", 32'(psel), 32'd0);
        consume();

        // write with three wait states
        pready = 1'b0;
        prdata = 32'h1234_5678;
        issue(1'b1, 12'h004, 32'hDEAD_BEEF);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("wr_access_sel_en", {30'd0, psel, penable}, 32'd3);
            chk("wr_paddr", 32'(paddr), 32'h004);
            chk("wr_pwdata", pwdata, 32'hDEAD_BEEF);
            chk("wr_pwrite", 32'(pwrite), 32'd1);
            if (i == 3) pready = 1'b1;
            @(negedge clk);
        end
        pready = 1'b0;
        chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_rsp_rdata", rsp_rdata, 32'd0);
        chk("wr_rsp_slverr", 32'(rsp_slverr), 32'd0);
        consume();

        // slave error
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'hAAAA_5555;
        issue(1'b0, 12'h008, 32'h0);
        chk("err_paddr", 32'(paddr), 32'h008);
        repeat (2) @(negedge clk);
        pslverr = 1'b0;
        pready  = 1'b0;
        chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("err_rsp_slverr", 32'(rsp_slverr), 32'd1);
        chk("err_rsp_timeout", 32'(rsp_timeout), 32'd0);
        consume();

        // timeout with pready held low
        prdata = 32'hFFFF_0000;
        issue(1'b0, 12'h010, 32'h0);
        @(negedge clk);
        n_acc = 0;
        for (int i = 0; i < 40 && psel && penable; i++) begin
            n_acc++;
            @(negedge clk);
        end
        chk("to_access_cycles", 32'(n_acc), 32'd16);
        chk("to_psel_pen", {30'd0, psel, penable}, 32'd0);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_slverr", 32'(rsp_slverr), 32'd1);
        chk("to_rsp_timeout", 32'(rsp_timeout), 32'd1);
        chk("to_rsp_rdata", rsp_rdata, 32'd0);
        consume();

        // pready on the sixteenth ACCESS cycle completes normally
        prdata = 32'h0BAD_F00D;
        issue(1'b0, 12'h014, 32'h0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            chk("edge_in_access", {30'd0, psel, penable}, 32'd3);
            if (i == 15) pready = 1'b1;
            @(negedge clk);
        end
        pready = 1'b0;
        prdata = 32'h0;
        chk("edge_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("edge_rsp_timeout", 32'(rsp_timeout), 32'd0);
        chk("edge_rsp_slverr", 32'(rsp_slverr), 32'd0);
        chk("edge_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);

        // response backpressure on the held response
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_psel", 32'(psel), 32'd0);
            @(negedge clk);
        end
        consume();

        // reset in the middle of ACCESS
        issue(1'b1, 12'h020, 32'h5555_AAAA);
        repeat (2) @(negedge clk);
        chk("mid_in_access", {30'd0, psel, penable}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_psel_pen", {30'd0, psel, penable}, 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        pready = 1'b1;
        prdata = 32'hCAFE_0001;
        issue(1'b0, 12'h00C, 32'h0);
        chk("post_paddr", 32'(paddr), 32'h00C);
        repeat (2) @(negedge clk);
        pready = 1'b0;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("post_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
        chk("post_rsp_timeout", 32'(rsp_timeout), 32'd0);
        consume();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
